// File: rtl/frame_stream_pkg.sv
// Shared types and constants for the frame streaming blocks.
// Sets the FSM encoding, the FIFO entry layout and the skid FIFO depth.
package frame_stream_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain,
        StDone
    } state_e;

    // Widest pixel carried through the FIFO; narrower DATA_W values zero-extend.
    localparam int unsigned PixelW = 32;

    localparam int unsigned FifoDepth = 2;
    localparam int unsigned CountW    = $clog2(FifoDepth + 1);

    typedef struct packed {
        logic [PixelW-1:0] data;
        logic              last;
        logic              frame_end;
    } fifo_entry_t;

endpackage

// File: rtl/stream_fifo2.sv
// Two-entry synchronous FIFO with a registered head and occupancy count.
// The caller guarantees no push while full unless it also pops that cycle.
module stream_fifo2
    import frame_stream_pkg::*;
#(
    parameter type entry_t = logic [7:0]
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  entry_t            push_data,
    input  logic              pop,
    output entry_t            head,
    output logic [CountW-1:0] count
);

    entry_t            mem_q [FifoDepth];
    entry_t            mem_d [FifoDepth];
    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic [CountW-1:0] count_q, count_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        count_d = count_q + CountW'(push) - CountW'(pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FifoDepth; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/frame_stream_source.sv
// Raster-order pixel streamer: reads a frame from a 1-cycle-latency memory
// and emits it one pixel per valid/ready transfer with row/frame flags.
module frame_stream_source
    import frame_stream_pkg::*;
#(
    parameter int unsigned DATA_W = PixelW,
    parameter int unsigned IMG_W  = 16,
    parameter int unsigned IMG_H  = 16,
    parameter int unsigned ADDR_W = $clog2(IMG_W * IMG_H)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tstart,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic              tvalid,
    input  logic              tready,
    output logic [DATA_W-1:0] tdata,
    output logic              tlast,
    output logic              tframe_end,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W-1:0] ColLast = ADDR_W'(IMG_W - 1);
    localparam logic [ADDR_W-1:0] RowLast = ADDR_W'(IMG_H - 1);

    logic [1:0]        rst_sync_q, rst_sync_d;
    logic              rst_sync_n;
    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] col_q, col_d;
    logic [ADDR_W-1:0] row_q, row_d;
    logic              infl_q, infl_d;
    logic              infl_last_q, infl_last_d;
    logic              infl_fend_q, infl_fend_d;
    logic              issue, push, pop, xfer, fifo_empty;
    logic [CountW-1:0] fifo_count;
    fifo_entry_t       push_entry, head_entry, out_entry;

    // Assertion is immediate; release is retimed to two clean edges.
    assign rst_sync_d = {rst_sync_q[0], 1'b1};
    assign rst_sync_n = rst_sync_q[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= rst_sync_d;
        end
    end

    // Returning read data bypasses the FIFO when it is empty, so the first
    // pixel is valid the cycle it arrives; it is pushed only if not taken.
    assign push_entry = '{data: PixelW'(mem_rd_data), last: infl_last_q, frame_end: infl_fend_q};
    assign fifo_empty = (fifo_count == '0);
    assign tvalid     = !fifo_empty || infl_q;
    assign xfer       = tvalid && tready;
    assign pop        = xfer && !fifo_empty;
    assign push       = infl_q && !(fifo_empty && tready);

    always_comb begin
        out_entry = '0;
        if (!fifo_empty) begin
            out_entry = head_entry;
        end else if (infl_q) begin
            out_entry = push_entry;
        end
    end

    assign tdata      = DATA_W'(out_entry.data);
    assign tlast      = out_entry.last;
    assign tframe_end = out_entry.frame_end;
    assign mem_rd_en  = issue;
    assign mem_addr   = addr_q;
    assign busy       = (state_q != StIdle);

    stream_fifo2 #(
        .entry_t (fifo_entry_t)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_sync_n),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .head      (head_entry),
        .count     (fifo_count)
    );

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        col_d       = col_q;
        row_d       = row_q;
        infl_d      = 1'b0;
        infl_last_d = infl_last_q;
        infl_fend_d = infl_fend_q;
        issue       = 1'b0;
        done        = 1'b0;
        case (state_q)
            StIdle: begin
                if (tstart) begin
                    state_d = StRun;
                    addr_d  = '0;
                    col_d   = '0;
                    row_d   = '0;
                end
            end
            StRun: begin
                // Count plus in-flight read never exceeds the FIFO depth.
                issue = (32'(fifo_count) + 32'(infl_q)) < FifoDepth;
                if (issue) begin
                    infl_d      = 1'b1;
                    infl_last_d = (col_q == ColLast);
                    infl_fend_d = (col_q == ColLast) && (row_q == RowLast);
                    addr_d      = addr_q + ADDR_W'(1);
                    if (col_q == ColLast) begin
                        col_d = '0;
                        if (row_q != RowLast) begin
                            row_d = row_q + ADDR_W'(1);
                        end else begin
                            state_d = StDrain;
                        end
                    end else begin
                        col_d = col_q + ADDR_W'(1);
                    end
                end
            end
            StDrain: begin
                if (xfer && out_entry.frame_end) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            col_q       <= '0;
            row_q       <= '0;
            infl_q      <= 1'b0;
            infl_last_q <= 1'b0;
            infl_fend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            col_q       <= col_d;
            row_q       <= row_d;
            infl_q      <= infl_d;
            infl_last_q <= infl_last_d;
            infl_fend_q <= infl_fend_d;
        end
    end

endmodule

// File: tb/tb_frame_stream_source.sv
// Scoreboard bench for frame_stream_source on a 4x4 frame with mem[i] = i + 100.
// Stimulus queues expected pixels; a negedge monitor checks every transfer.
module tb_frame_stream_source;

    localparam int unsigned W  = 4;
    localparam int unsigned H  = 4;
    localparam int unsigned N  = W * H;
    localparam int unsigned AW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          tstart;
    logic          mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_rd_data = '0;
    logic          tvalid;
    logic          tready;
    logic [31:0]   tdata;
    logic          tlast;
    logic          tframe_end;
    logic          busy;
    logic          done;

    typedef struct {
        logic [31:0] data;
        logic        last;
        logic        fend;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   cyc         = 0;
    int   start_cyc   = 0;
    int   rel         = 0;
    int   mode        = 0;
    int   exp_addr    = 0;
    int   rd_count    = 0;
    int   frame_xfers = 0;
    int   xfer_total  = 0;
    int   out_cnt     = 0;
    bit   expect_done = 1'b0;
    bit   check_busy  = 1'b0;
    bit   prev_stall  = 1'b0;
    logic [31:0] prev_data;
    logic        prev_last, prev_fend;

    frame_stream_source #(
        .DATA_W (32),
        .IMG_W  (W),
        .IMG_H  (H)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .tstart      (tstart),
        .mem_rd_en   (mem_rd_en),
        .mem_addr    (mem_addr),
        .mem_rd_data (mem_rd_data),
        .tvalid      (tvalid),
        .tready      (tready),
        .tdata       (tdata),
        .tlast       (tlast),
        .tframe_end  (tframe_end),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    // 1-cycle-latency memory
    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= 32'(mem_addr) + 32'd100;
    end

    // Cycle counter and tready pattern, applied 1 time unit after each edge
    always @(posedge clk) begin
        cyc++;
        #1;
        rel = cyc - start_cyc;
        case (mode)
            1:       tready = !((rel >= 5 && rel <= 9) || (rel > 9 && rel % 3 == 0));
            2:       tready = 1'b0;
            default: tready = 1'b1;
        endcase
    end

    task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall  = 1'b0;
            expect_done = 1'b0;
            out_cnt     = 0;
        end else begin
            if (expect_done) begin
                compare("done_pulse", 32'(done), 32'd1);
                expect_done = 1'b0;
            end else if (done) begin
                compare("done_spurious", 32'(done), 32'd0);
            end
            if (check_busy) compare("busy_in_frame", 32'(busy), 32'd1);
            if (mem_rd_en) begin
                compare("mem_addr", 32'(mem_addr), 32'(exp_addr));
                compare("outstanding_le_2", 32'(out_cnt + 1 <= 2), 32'd1);
                exp_addr++;
                rd_count++;
            end
            if (prev_stall) begin
                compare("stall_tvalid", 32'(tvalid), 32'd1);
                compare("stall_tdata", tdata, prev_data);
                compare("stall_flags", {30'd0, tlast, tframe_end}, {30'd0, prev_last, prev_fend});
            end
            if (tvalid && tready) begin
                if (exp_q.size() == 0) begin
                    compare("unexpected_pixel", tdata, 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    compare("tdata", tdata, e.data);
                    compare("tlast", 32'(tlast), 32'(e.last));
                    compare("tframe_end", 32'(tframe_end), 32'(e.fend));
                end
                frame_xfers++;
                xfer_total++;
                if (tframe_end) expect_done = 1'b1;
            end
            out_cnt    = out_cnt + int'(mem_rd_en) - int'(tvalid && tready);
            prev_stall = tvalid && !tready;
            prev_data  = tdata;
            prev_last  = tlast;
            prev_fend  = tframe_end;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse tstart for one cycle; queue the expected frame when it should be accepted.
    task automatic start_frame(input bit accepted);
        tstart = 1'b1;
        if (accepted) begin
            start_cyc   = cyc;
            exp_addr    = 0;
            rd_count    = 0;
            frame_xfers = 0;
            for (int i = 0; i < N; i++) begin
                exp_t e;
                e.data = 32'd100 + 32'(i);
                e.last = (i % W) == W - 1;
                e.fend = (i == N - 1);
                exp_q.push_back(e);
            end
        end
        tick();
        tstart = 1'b0;
    endtask

    task automatic wait_done(output int at_cyc);
        at_cyc = -1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (done) begin
                at_cyc = cyc;
                break;
            end
        end
        if (at_cyc < 0) compare("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic end_checks();
        compare("queue_drained", 32'(exp_q.size()), 32'd0);
        compare("frame_xfers", 32'(frame_xfers), 32'(N));
        compare("frame_reads", 32'(rd_count), 32'(N));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d;
        int base;
        rst_n  = 1'b0;
        tstart = 1'b0;
        repeat (3) tick();
        compare("rst_tvalid", 32'(tvalid), 32'd0);
        compare("rst_busy", 32'(busy), 32'd0);
        compare("rst_done", 32'(done), 32'd0);
        compare("rst_rd_en", 32'(mem_rd_en), 32'd0);
        compare("rst_addr", 32'(mem_addr), 32'd0);
        compare("rst_tdata", tdata, 32'd0);
        compare("rst_flags", {30'd0, tlast, tframe_end}, 32'd0);
        rst_n = 1'b1;
        repeat (3) tick();

        // Back-to-back with latency and done timing
        start_frame(1'b1);
        @(negedge clk);
        compare("lat_rd_en_c1", 32'(mem_rd_en), 32'd1);
        compare("lat_tvalid_c1", 32'(tvalid), 32'd0);
        @(negedge clk);
        compare("lat_tvalid_c2", 32'(tvalid), 32'd1);
        wait_done(d);
        compare("done_cycle", 32'(d - start_cyc), 32'(N + 2));
        end_checks();

        // Backpressure pattern
        tick();
        mode = 1;
        start_frame(1'b1);
        wait_done(d);
        end_checks();
        mode = 0;

        // tstart during frame is ignored
        tick();
        start_frame(1'b1);
        check_busy = 1'b1;
        repeat (5) tick();
        start_frame(1'b0);
        wait_done(d);
        check_busy = 1'b0;
        end_checks();
        repeat (4) tick();
        compare("idle_after_ignored_start", 32'(busy), 32'd0);
        compare("no_extra_reads", 32'(rd_count), 32'(N));

        // Asynchronous reset mid-frame
        start_frame(1'b1);
        repeat (7) tick();
        compare("pre_reset_tvalid", 32'(tvalid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        compare("async_rst_tvalid", 32'(tvalid), 32'd0);
        compare("async_rst_busy", 32'(busy), 32'd0);
        compare("async_rst_rd_en", 32'(mem_rd_en), 32'd0);
        exp_q.delete();
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (4) tick();
        start_frame(1'b1);
        wait_done(d);
        end_checks();

        // tready low from start
        tick();
        mode = 2;
        start_frame(1'b1);
        repeat (5) tick();
        @(negedge clk);
        compare("hold_reads", 32'(rd_count), 32'd2);
        compare("hold_tvalid", 32'(tvalid), 32'd1);
        compare("hold_tdata", tdata, 32'd100);
        tick();
        mode = 0;
        wait_done(d);
        end_checks();

        // Back-to-back frames
        tick();
        base = xfer_total;
        start_frame(1'b1);
        wait_done(d);
        tick();
        start_frame(1'b1);
        wait_done(d);
        compare("b2b_done_cycle", 32'(d - start_cyc), 32'(N + 2));
        end_checks();
        compare("b2b_total", 32'(xfer_total - base), 32'(2 * N));

        repeat (3) tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
